// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding,
// key map and the row-priority helper.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  localparam int DEFAULT_TICK_DIV = 100_000;

  // Indexed {row_idx, col_idx}; entry 0 is row 0 / column 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
// Shared between the keypad scanner and the display multiplexer.
module scan_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clock,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, debounced
// press/release, hex code presented once per press.
// Handshake: key_valid stays high with key_code stable until a cycle with
// key_ack = 1; key_ack is ignored while key_valid = 0.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_TICKS);

  logic        tick;
  logic [3:0]  row_meta_q, row_sync_q;
  scan_state_e state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d, row_idx_q, row_idx_d, next_col;
  logic [3:0]  count_q, count_d, count_inc, col_q, col_d;
  logic        key_held_q, key_held_d, accept_q, accept_d;
  logic [3:0]  accept_code_q, accept_code_d, key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d, overrun_q, overrun_d;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign next_col  = col_idx_q + 2'd1;
  assign count_inc = count_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    count_d       = count_q;
    col_d         = col_q;
    key_held_d    = key_held_q;
    accept_d      = 1'b0;
    accept_code_d = accept_code_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_sync_q != 4'hF) begin
            row_idx_d = lowest_low_row(row_sync_q);
            if (DEBOUNCE_TICKS == 1) begin
              accept_d      = 1'b1;
              accept_code_d = KEY_MAP[{lowest_low_row(row_sync_q), col_idx_q}];
              count_d       = 4'd0;
              key_held_d    = 1'b1;
              state_d       = HELD;
            end else begin
              count_d = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = next_col;
            col_d     = ~(4'b0001 << next_col);
          end
        end
        DEBOUNCE: begin
          if (!row_sync_q[row_idx_q]) begin
            if (count_inc == DEB_N) begin
              accept_d      = 1'b1;
              accept_code_d = KEY_MAP[{row_idx_q, col_idx_q}];
              count_d       = 4'd0;
              key_held_d    = 1'b1;
              state_d       = HELD;
            end else begin
              count_d = count_inc;
            end
          end else begin
            count_d   = 4'd0;
            state_d   = SCAN;
            col_idx_d = next_col;
            col_d     = ~(4'b0001 << next_col);
          end
        end
        HELD: begin
          // Release is debounced the same way as the press.
          if (row_sync_q[row_idx_q]) begin
            if (count_inc == DEB_N) begin
              count_d    = 4'd0;
              key_held_d = 1'b0;
              state_d    = SCAN;
              col_idx_d  = next_col;
              col_d      = ~(4'b0001 << next_col);
            end else begin
              count_d = count_inc;
            end
          end else begin
            count_d = 4'd0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (accept_q) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = accept_code_q;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_valid_q && key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      state_q       <= SCAN;
      col_idx_q     <= 2'd0;
      row_idx_q     <= 2'd0;
      count_q       <= 4'd0;
      col_q         <= 4'b1110;
      key_held_q    <= 1'b0;
      accept_q      <= 1'b0;
      accept_code_q <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      row_meta_q    <= row;
      row_sync_q    <= row_meta_q;
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      count_q       <= count_d;
      col_q         <= col_d;
      key_held_q    <= key_held_d;
      accept_q      <= accept_d;
      accept_code_q <= accept_code_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad on the
// row/col lines and a queue of expected key codes.
module tb_keypad_scanner;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held, overrun;
  logic       key_ack = 1'b0;
  logic [15:0] pressed = '0;  // bit r*4+c = key at row r, column c held down

  logic [3:0] exp_q[$];
  logic [3:0] col_pat[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  keypad_scanner #(.TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = col;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clock);
      if (col == target && prev != target) ok = 1'b1;
      prev = col;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_held(input logic level, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (key_held == level) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pop_compare(input string tag);
    logic [3:0] e;
    e = 4'bx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check(tag, 32'(key_code), 32'(e));
  endtask

  task automatic wait_valid(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (key_valid) ok = 1'b1;
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
    if (ok) pop_compare(tag);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  initial begin
    step(3);
    check("rst_col", 32'(col), 32'(4'b1110));
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Idle scan: each column is driven for TICK_DIV clocks in turn.
    rst_n = 1'b1;
    check("idle_col_0", 32'(col), 32'(col_pat[0]));
    for (int k = 1; k < 40; k++) begin
      step(1);
      check($sformatf("idle_col_%0d", k), 32'(col), 32'(col_pat[(k / TICK_DIV) % 4]));
      check("idle_valid", 32'(key_valid), 32'd0);
    end

    // Key 6 (row 1, column 2): valid DEB*TICK_DIV+1 clocks after column 2 is driven.
    pressed = 16'(1 << 6);
    exp_q.push_back(4'h6);
    wait_col(4'b1011, "wait_col2");
    for (int i = 1; i <= DEB * TICK_DIV + 1; i++) begin
      step(1);
      if (i == DEB * TICK_DIV) begin
        check("k6_not_yet_valid", 32'(key_valid), 32'd0);
        check("k6_col_frozen", 32'(col), 32'(4'b1011));
      end
    end
    check("k6_valid", 32'(key_valid), 32'd1);
    check("k6_held", 32'(key_held), 32'd1);
    check("k6_col", 32'(col), 32'(4'b1011));
    pop_compare("k6_code");
    ack_pulse();
    check("k6_ack_valid", 32'(key_valid), 32'd0);
    step(40);
    check("k6_no_repeat", 32'(key_valid), 32'd0);
    check("k6_still_held", 32'(key_held), 32'd1);
    pressed = '0;
    wait_held(1'b0, "k6_release");
    check("k6_resume_col3", 32'(col), 32'(4'b0111));
    check("k6_release_valid", 32'(key_valid), 32'd0);

    // One-tick glitch on row 0 at column 0.
    wait_col(4'b1110, "wait_col0");
    pressed = 16'(1 << 0);
    step(TICK_DIV);
    check("glitch_detect_col", 32'(col), 32'(4'b1110));
    step(1);
    pressed = '0;
    step(TICK_DIV - 1);
    check("glitch_next_col", 32'(col), 32'(4'b1101));
    check("glitch_no_valid", 32'(key_valid), 32'd0);
    step(30);
    check("glitch_no_valid_late", 32'(key_valid), 32'd0);

    // Overrun: 5 pending, D pressed without ack.
    pressed = 16'(1 << 5);
    exp_q.push_back(4'h5);
    wait_valid("k5_code");
    pressed = '0;
    wait_held(1'b0, "k5_release");
    pressed = 16'(1 << 15);
    wait_held(1'b1, "kd_held");
    step(1);
    check("ovr_code_kept", 32'(key_code), 32'h5);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(key_valid), 32'd1);
    ack_pulse();
    check("ovr_ack_valid", 32'(key_valid), 32'd0);
    check("ovr_ack_flag", 32'(overrun), 32'd0);
    pressed = '0;
    wait_held(1'b0, "kd_release");

    // Rows 2 and 3 together on column 0: lowest row wins.
    pressed = 16'((1 << 8) | (1 << 12));
    exp_q.push_back(4'h7);
    wait_valid("prio_code");
    pressed = '0;
    wait_held(1'b0, "prio_release");

    // Ack in the same cycle as a new accept loads the new key.
    pressed = 16'(1 << 10);
    exp_q.push_back(4'h9);
    wait_held(1'b1, "k9_held");
    ack_pulse();
    pop_compare("k9_code");
    check("k9_valid", 32'(key_valid), 32'd1);
    check("k9_overrun", 32'(overrun), 32'd0);
    ack_pulse();
    check("k9_ack_valid", 32'(key_valid), 32'd0);
    pressed = '0;
    wait_held(1'b0, "k9_release");

    // Asynchronous reset while HELD.
    pressed = 16'(1 << 6);
    wait_held(1'b1, "rst_held_entry");
    step(2);
    #1 rst_n = 1'b0;
    #1;
    check("async_col", 32'(col), 32'(4'b1110));
    check("async_held", 32'(key_held), 32'd0);
    check("async_valid", 32'(key_valid), 32'd0);
    pressed = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check("post_rst_col", 32'(col), 32'(4'b1110));
    check("post_rst_valid", 32'(key_valid), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display scanner: drives the columns of a 4x4 matrix keypad (Pmod KYPD layout) one at a time and reads the rows back.
- Debounces press and release, and converts the key position to a 4-bit hex code.
- Presents each press once to downstream logic (clock-set / mode control) through a valid/ack handshake.

Parameters:
- TICK_DIV, 100_000, system clocks per scan tick (1 kHz at 100 MHz); must be >= 2.
- DEBOUNCE_TICKS, 4, consecutive agreeing tick samples needed to accept a press or a release; range 1..15.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active low, externally pulled up; asynchronous to clock.
- col  out  4  column drive, active low, exactly one bit low at all times.
- key_code  out  4  hex code of the accepted key.
- key_valid  out  1  high while an unacknowledged key is pending.
- key_ack  in  1  consumer acknowledge, sampled only while key_valid = 1.
- key_held  out  1  high while the accepted key remains physically pressed (state HELD).
- overrun  out  1  sticky flag: a press was accepted while key_valid was already 1.

Behaviour:
- Reset (async assert, sync deassert use) sets:
  - col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, overrun = 0.
  - Tick counter = 0, column index = 0, debounce count = 0, state = SCAN.
- Row input: 2-flop synchronizer, reset value 4'b1111. All row decisions use the synchronized value.
- Tick generator: counter 0..TICK_DIV-1; tick = 1 for one clock when counter = TICK_DIV-1, then counter wraps to 0. A column is therefore driven for a full tick period before it is sampled (settle time).
- Row priority: the lowest active row index (synchronized bit = 0) wins; other simultaneously pressed rows in the same column are ignored.
- State machine (evaluated only on tick cycles):
  - SCAN:
    - Any row low -> latch col_idx/row_idx, count = 1, go DEBOUNCE; col holds.
    - Else col_idx = col_idx+1 (wraps 3->0) and col = ~(1<<col_idx).
  - DEBOUNCE:
    - Latched row still low -> count+1.
    - Latched row high -> count = 0, back to SCAN, advance to next column.
    - When count reaches DEBOUNCE_TICKS -> accept key, count = 0, go HELD. With DEBOUNCE_TICKS = 1 this happens on the SCAN-detect tick, going straight to HELD.
  - HELD:
    - key_held = 1; col holds.
    - Latched row high -> count+1; latched row low -> count = 0.
    - When count reaches DEBOUNCE_TICKS -> key_held = 0, go SCAN, advance to next column.
- Key map (row, col0..col3):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = 0 F E D
- Accept rules:
  - key_valid = 0: key_code <= mapped code and key_valid <= 1, on the clock after the accepting tick.
  - key_valid = 1 and no ack that cycle: new key discarded, key_code unchanged, overrun <= 1.
  - Ack in the same cycle as an accept: new key loaded, key_valid stays 1, overrun unchanged.
- Handshake:
  - key_ack while key_valid = 1 -> key_valid <= 0 and overrun <= 0 next cycle.
  - key_ack while key_valid = 0 is ignored.
- Latency: a press stable from time t is accepted within about (4 + DEBOUNCE_TICKS) ticks plus 3 clocks.
- A bounce shorter than DEBOUNCE_TICKS ticks never produces key_valid.
- Holding a key produces exactly one event; no auto-repeat.
- Reset mid-debounce or mid-held returns to SCAN at column 0 with no event.

Decomposition:
- Shared package holds:
  - KEY_MAP constant (16 x 4-bit, indexed {row_idx, col_idx}).
  - State encoding SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2.
  - DEFAULT_TICK_DIV constant.
- One sub-module: scan_tick_gen (parameter TICK_DIV; ports clock, rst_n, tick). It is reusable by the display mux clock.

Test Plan:
- TICK_DIV = 4, DEBOUNCE_TICKS = 3, all rows high for 40 clocks -> col cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; key_valid stays 0.
- Hold row[1] low when col = 1011 (col2) -> col freezes at 1011, key_code = 4'h6, key_valid = 1 one clock after the 3rd agreeing tick, key_held = 1; release -> key_held = 0 after 3 high ticks, scan resumes at col3.
- Row[0] glitch low for 1 tick at col0 -> no key_valid, scan continues to col1.
- Accept key "5", no ack, then press "D" -> key_code stays 4'h5, overrun = 1; pulse key_ack -> key_valid = 0, overrun = 0.
- Rows 2 and 3 low together at col0 -> key_code = 4'h7 (row-priority check).
- Assert rst_n = 0 during HELD -> col = 1110, key_held = 0, key_valid = 0 immediately (async).
